// File: rtl/gate_test_pkg.sv
// -----------------------------------------------------------------------------
// gate_test_pkg
// Shared definitions for the basic-gate self-test engine.
//   state_e      : controller states (IDLE, SETTLE, CHECK, DONE)
//   NUM_VECS     : number of {a,b} input combinations swept per pass
//   G_*          : bit positions of each gate output on the 7-bit y bus
// -----------------------------------------------------------------------------
package gate_test_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int NUM_VECS  = 4;
  localparam int NUM_GATES = 7;

  localparam int G_AND   = 0;
  localparam int G_OR    = 1;
  localparam int G_NOT_A = 2;
  localparam int G_NAND  = 3;
  localparam int G_NOR   = 4;
  localparam int G_XOR   = 5;
  localparam int G_XNOR  = 6;

endpackage

// File: rtl/gate_golden_model.sv
// -----------------------------------------------------------------------------
// gate_golden_model
// Purely combinational reference truth table for the two-input gate block.
// Ports:
//   a, b      : stimulus currently applied to the gate block
//   expected  : 7-bit expected gate outputs, indexed by the G_* constants
// -----------------------------------------------------------------------------
module gate_golden_model
  import gate_test_pkg::*;
(
  input  logic                 a,
  input  logic                 b,
  output logic [NUM_GATES-1:0] expected
);

  // Reference value of every gate for the current {a,b}
  always_comb begin
    expected          = {NUM_GATES{1'b0}};
    expected[G_AND]   = a & b;
    expected[G_OR]    = a | b;
    expected[G_NOT_A] = ~a;
    expected[G_NAND]  = ~(a & b);
    expected[G_NOR]   = ~(a | b);
    expected[G_XOR]   = a ^ b;
    expected[G_XNOR]  = ~(a ^ b);
  end

endmodule

// File: rtl/gate_bist_checker.sv
// -----------------------------------------------------------------------------
// gate_bist_checker
// On-chip self-test for the basic-gate block: sweeps {a,b} through 00,01,10,11
// (PASSES times), waits SETTLE_CYCLES per vector, compares y to the golden
// truth table and reports the result.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : level-sampled run request (ignored while busy)
//   a, b       : stimulus to the gate block
//   y          : gate block outputs (AND,OR,NOT a,NAND,NOR,XOR,XNOR)
//   busy       : run in progress
//   done       : run finished, held until next start or reset
//   pass       : no failing checks in the finished run
//   err_count  : failing vector checks, saturating
//   fail_vec   : {a,b} of the first failing check
//   fail_mask  : y ^ expected at the first failing check
// -----------------------------------------------------------------------------
module gate_bist_checker
  import gate_test_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1,
  parameter int ERR_W         = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 a,
  output logic                 b,
  input  logic [NUM_GATES-1:0] y,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_W-1:0]     err_count,
  output logic [1:0]           fail_vec,
  output logic [NUM_GATES-1:0] fail_mask
);

  localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES);
  localparam logic [7:0]       LAST_PASS   = 8'(PASSES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ONE     = {{(ERR_W-1){1'b0}}, 1'b1};

  state_e               state_r, state_s;
  logic [1:0]           vec_r, vec_s;
  logic [7:0]           pass_cnt_r, pass_cnt_s;
  logic [3:0]           settle_cnt_r, settle_cnt_s;
  logic                 first_fail_r, first_fail_s;
  logic                 busy_r, busy_s;
  logic                 done_r, done_s;
  logic                 pass_r, pass_s;
  logic [ERR_W-1:0]     err_r, err_s;
  logic [ERR_W-1:0]     err_upd_s;
  logic [1:0]           fail_vec_r, fail_vec_s;
  logic [NUM_GATES-1:0] fail_mask_r, fail_mask_s;
  logic [NUM_GATES-1:0] golden_s;
  logic [NUM_GATES-1:0] diff_s;
  logic                 mismatch_s;

  // Stimulus is the registered vector itself, so a/b are glitch-free
  assign a         = vec_r[1];
  assign b         = vec_r[0];
  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign err_count = err_r;
  assign fail_vec  = fail_vec_r;
  assign fail_mask = fail_mask_r;

  gate_golden_model u_golden (
    .a        (vec_r[1]),
    .b        (vec_r[0]),
    .expected (golden_s)
  );

  // Compare and saturating error update for the vector under check
  always_comb begin
    diff_s     = y ^ golden_s;
    mismatch_s = |diff_s;
    err_upd_s  = err_r;
    if (mismatch_s && (err_r != ERR_MAX)) begin
      err_upd_s = err_r + ERR_ONE;
    end else begin
      err_upd_s = err_r;
    end
  end

  // Next-state and next-output logic of the sweep controller
  always_comb begin
    state_s      = state_r;
    vec_s        = vec_r;
    pass_cnt_s   = pass_cnt_r;
    settle_cnt_s = settle_cnt_r;
    first_fail_s = first_fail_r;
    busy_s       = busy_r;
    done_s       = done_r;
    pass_s       = pass_r;
    err_s        = err_r;
    fail_vec_s   = fail_vec_r;
    fail_mask_s  = fail_mask_r;

    case (state_r)
      // A finished run restarts exactly like an idle one
      IDLE, DONE: begin
        if (start) begin
          state_s      = SETTLE;
          vec_s        = 2'b00;
          pass_cnt_s   = 8'd0;
          settle_cnt_s = SETTLE_LOAD;
          first_fail_s = 1'b0;
          busy_s       = 1'b1;
          done_s       = 1'b0;
          pass_s       = 1'b0;
          err_s        = {ERR_W{1'b0}};
          fail_vec_s   = 2'b00;
          fail_mask_s  = {NUM_GATES{1'b0}};
        end else begin
          state_s = state_r;
        end
      end

      SETTLE: begin
        settle_cnt_s = settle_cnt_r - 4'd1;
        if (settle_cnt_r == 4'd1) begin
          state_s = CHECK;
        end else begin
          state_s = SETTLE;
        end
      end

      CHECK: begin
        err_s = err_upd_s;
        if (mismatch_s && !first_fail_r) begin
          first_fail_s = 1'b1;
          fail_vec_s   = vec_r;
          fail_mask_s  = diff_s;
        end else begin
          first_fail_s = first_fail_r;
        end

        if ((vec_r == 2'b11) && (pass_cnt_r == LAST_PASS)) begin
          state_s = DONE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          pass_s  = (err_upd_s == {ERR_W{1'b0}});
        end else begin
          state_s      = SETTLE;
          vec_s        = vec_r + 2'd1;
          settle_cnt_s = SETTLE_LOAD;
          if (vec_r == 2'b11) begin
            pass_cnt_s = pass_cnt_r + 8'd1;
          end else begin
            pass_cnt_s = pass_cnt_r;
          end
        end
      end

      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and result registers; reset discards any partial result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      vec_r        <= 2'b00;
      pass_cnt_r   <= 8'd0;
      settle_cnt_r <= 4'd0;
      first_fail_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
      err_r        <= {ERR_W{1'b0}};
      fail_vec_r   <= 2'b00;
      fail_mask_r  <= {NUM_GATES{1'b0}};
    end else begin
      state_r      <= state_s;
      vec_r        <= vec_s;
      pass_cnt_r   <= pass_cnt_s;
      settle_cnt_r <= settle_cnt_s;
      first_fail_r <= first_fail_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      pass_r       <= pass_s;
      err_r        <= err_s;
      fail_vec_r   <= fail_vec_s;
      fail_mask_r  <= fail_mask_s;
    end
  end

endmodule

// File: tb/tb_gate_bist_checker.sv
// -----------------------------------------------------------------------------
// tb_gate_bist_checker
// Directed bench for gate_bist_checker. Three instances:
//   u_dut0 : defaults, y = reference gates with an optional stuck-at-0 mask
//   u_dut1 : PASSES=8, y = inverted reference (every check fails)
//   u_dut2 : SETTLE_CYCLES=1, y = reference gates
// -----------------------------------------------------------------------------
module tb_gate_bist_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start0, start1, start2;
  logic       a0, b0, a1, b1, a2, b2;
  logic [6:0] y0, y1, y2;
  logic       busy0, busy1, busy2;
  logic       done0, done1, done2;
  logic       pass0, pass1, pass2;
  logic [3:0] err0, err1, err2;
  logic [1:0] fv0, fv1, fv2;
  logic [6:0] fm0, fm1, fm2;
  logic [6:0] stuck0;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference truth table, bit0..bit6 = AND,OR,NOT a,NAND,NOR,XOR,XNOR
  function automatic logic [6:0] ref_gates(input logic ia, input logic ib);
    return {~(ia ^ ib), ia ^ ib, ~(ia | ib), ~(ia & ib), ~ia, ia | ib, ia & ib};
  endfunction

  assign y0 = ref_gates(a0, b0) & ~stuck0;
  assign y1 = ~ref_gates(a1, b1);
  assign y2 = ref_gates(a2, b2);

  gate_bist_checker u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0), .y(y0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .fail_vec(fv0), .fail_mask(fm0)
  );

  gate_bist_checker #(.SETTLE_CYCLES(2), .PASSES(8), .ERR_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .y(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_vec(fv1), .fail_mask(fm1)
  );

  gate_bist_checker #(.SETTLE_CYCLES(1), .PASSES(1), .ERR_W(4)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .y(y2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .fail_vec(fv2), .fail_mask(fm2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; start2 = 1'b0; stuck0 = 7'd0;
    step(); step();

    // Reset state
    chk("rst_a",     32'(a0),    32'd0);
    chk("rst_b",     32'(b0),    32'd0);
    chk("rst_busy",  32'(busy0), 32'd0);
    chk("rst_done",  32'(done0), 32'd0);
    chk("rst_pass",  32'(pass0), 32'd0);
    chk("rst_err",   32'(err0),  32'd0);
    chk("rst_fvec",  32'(fv0),   32'd0);
    chk("rst_fmask", 32'(fm0),   32'd0);
    rst = 1'b0;
    step();

    // Good gates, one-cycle start pulse: 12 busy cycles, vector every 3 edges
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    chk("t1_busy0", 32'(busy0), 32'd1);
    chk("t1_ab0",   32'({a0, b0}), 32'd0);
    for (int i = 1; i < 12; i++) begin
      step();
      chk("t1_busy", 32'(busy0), 32'd1);
      chk("t1_ab",   32'({a0, b0}), 32'(i / 3));
    end
    step();
    chk("t1_done",  32'(done0), 32'd1);
    chk("t1_busyd", 32'(busy0), 32'd0);
    chk("t1_pass",  32'(pass0), 32'd1);
    chk("t1_err",   32'(err0),  32'd0);
    chk("t1_fmask", 32'(fm0),   32'd0);
    chk("t1_ab11",  32'({a0, b0}), 32'd3);

    // XOR stuck at 0: fails at 01 and 10
    stuck0 = 7'b0100000;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    chk("t2_restart_done", 32'(done0), 32'd0);
    repeat (12) step();
    chk("t2_done",  32'(done0), 32'd1);
    chk("t2_err",   32'(err0),  32'd2);
    chk("t2_fvec",  32'(fv0),   32'd1);
    chk("t2_fmask", 32'(fm0),   32'h20);
    chk("t2_pass",  32'(pass0), 32'd0);

    // start held high: one run only, then restart from DONE
    stuck0 = 7'd0;
    start0 = 1'b1;
    step();
    chk("t3_busy",  32'(busy0), 32'd1);
    chk("t3_err0",  32'(err0),  32'd0);
    repeat (11) step();
    chk("t3_still_busy", 32'(busy0), 32'd1);
    step();
    chk("t3_done",  32'(done0), 32'd1);
    chk("t3_pass",  32'(pass0), 32'd1);
    step();
    chk("t3_redone", 32'(done0), 32'd0);
    chk("t3_rebusy", 32'(busy0), 32'd1);
    chk("t3_reerr",  32'(err0),  32'd0);
    start0 = 1'b0;
    repeat (12) step();
    chk("t3_done2", 32'(done0), 32'd1);

    // Reset during CHECK of vector 10 with a partial error recorded
    stuck0 = 7'b0100000;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    repeat (8) step();
    chk("t4_ab10",   32'({a0, b0}), 32'd2);
    chk("t4_errpre", 32'(err0), 32'd1);
    rst = 1'b1;
    step();
    chk("t4_a",     32'(a0),    32'd0);
    chk("t4_b",     32'(b0),    32'd0);
    chk("t4_busy",  32'(busy0), 32'd0);
    chk("t4_done",  32'(done0), 32'd0);
    chk("t4_err",   32'(err0),  32'd0);
    chk("t4_fvec",  32'(fv0),   32'd0);
    chk("t4_fmask", 32'(fm0),   32'd0);
    rst = 1'b0;
    stuck0 = 7'd0;
    step();
    chk("t4_idle_busy", 32'(busy0), 32'd0);
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    repeat (12) step();
    chk("t4_fresh_done", 32'(done0), 32'd1);
    chk("t4_fresh_pass", 32'(pass0), 32'd1);
    chk("t4_fresh_err",  32'(err0),  32'd0);

    // PASSES=8, inverted outputs: 32 failures, saturating at 15
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (cyc = 1; cyc <= 200; cyc++) begin
      step();
      if (done1) break;
    end
    chk("t5_latency", 32'(cyc),  32'd96);
    chk("t5_err",     32'(err1), 32'd15);
    chk("t5_fvec",    32'(fv1),  32'd0);
    chk("t5_fmask",   32'(fm1),  32'h7F);
    chk("t5_pass",    32'(pass1), 32'd0);
    chk("t5_busy",    32'(busy1), 32'd0);

    // SETTLE_CYCLES=1: vector every 2 edges, done after 8
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    chk("t6_ab0", 32'({a2, b2}), 32'd0);
    for (int i = 1; i < 8; i++) begin
      step();
      chk("t6_busy", 32'(busy2), 32'd1);
      chk("t6_ab",   32'({a2, b2}), 32'(i / 2));
    end
    step();
    chk("t6_done", 32'(done2), 32'd1);
    chk("t6_pass", 32'(pass2), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
